// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
//
// Round-robin arbiter that lets NCH independent requesters (instruction fetch,
// data load/store, debug, ...) share one external memory bus. One transaction
// is outstanding at a time; each one walks IDLE -> ISSUE -> WAIT -> DONE.
//
// Parameters
//   NCH      number of requester channels (>= 2)
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  WAIT cycles before a transaction is aborted (timeout build only)
//
// Build option
//   MEM_ARB_TIMEOUT_EN  when defined, a WAIT-cycle counter aborts transactions
//                       that see no MEM_data_ready within TIMEOUT cycles and
//                       flags them with O_error. When undefined, O_error is
//                       tied low and WAIT lasts until MEM_data_ready.
//
// Ports (channel i of a flattened bus occupies [i*W +: W])
//   I_clk           clock, rising edge
//   I_reset         asynchronous active-high reset
//   I_exec          per-channel request, held until O_ack[i]
//   I_write         per-channel write flag (1 = write, 0 = read)
//   I_addr          per-channel address
//   I_data          per-channel write data
//   O_ack           one-cycle pulse: request latched
//   O_data_ready    one-cycle pulse: transaction complete
//   O_data          read data of the last completed read (shared)
//   O_error         one-cycle pulse alongside O_data_ready on timeout abort
//   O_busy          high in every state except IDLE
//   MEM_ready       memory can accept a command
//   MEM_exec        one-cycle command strobe
//   MEM_write       command is a write
//   MEM_addr        command address
//   MEM_data_out    write data to memory
//   MEM_data_in     read data from memory
//   MEM_data_ready  memory completion strobe (reads and writes)
// ============================================================================
module mem_arbiter #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    I_clk,
    input  logic                    I_reset,
    input  logic [NCH-1:0]          I_exec,
    input  logic [NCH-1:0]          I_write,
    input  logic [NCH*ADDR_W-1:0]   I_addr,
    input  logic [NCH*DATA_W-1:0]   I_data,
    output logic [NCH-1:0]          O_ack,
    output logic [NCH-1:0]          O_data_ready,
    output logic [DATA_W-1:0]       O_data,
    output logic                    O_error,
    output logic                    O_busy,
    input  logic                    MEM_ready,
    output logic                    MEM_exec,
    output logic                    MEM_write,
    output logic [ADDR_W-1:0]       MEM_addr,
    output logic [DATA_W-1:0]       MEM_data_out,
    input  logic [DATA_W-1:0]       MEM_data_in,
    input  logic                    MEM_data_ready
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;

    logic [GW-1:0]   pick;
    logic            pick_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter width follows TIMEOUT but is kept within 8..32 bits.
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

    logic [TW-1:0]   wait_cnt;
    logic            error_q;

    assign O_error = error_q;
`else
    logic            unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign O_error        = 1'b0;
`endif

    // Round-robin search: start one past the last served channel and wrap
    // modulo NCH, so the channel that just completed has lowest priority.
    // The modulo keeps the wrap correct for non-power-of-two NCH.
    always_comb begin
        logic [GW-1:0] cand;
        cand       = '0;
        pick       = last_grant;
        pick_valid = 1'b0;
        for (int off = 1; off <= NCH; off++) begin
            cand = GW'((int'(last_grant) + off) % NCH);
            if (!pick_valid && I_exec[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Transaction sequencer. All outputs are registered; pulse outputs
    // default low every cycle and are raised only on the transition into the
    // state where they must be visible.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= GW'(NCH - 1);
            O_ack        <= '0;
            O_data_ready <= '0;
            O_data       <= '0;
            O_busy       <= 1'b0;
            MEM_exec     <= 1'b0;
            MEM_write    <= 1'b0;
            MEM_addr     <= '0;
            MEM_data_out <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            O_ack        <= '0;
            O_data_ready <= '0;
            MEM_exec     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // MEM_addr/MEM_write/MEM_data_out double as the request
                    // latches and stay put until the next grant.
                    if (MEM_ready && pick_valid) begin
                        grant        <= pick;
                        MEM_addr     <= I_addr[pick*ADDR_W +: ADDR_W];
                        MEM_data_out <= I_data[pick*DATA_W +: DATA_W];
                        MEM_write    <= I_write[pick];
                        O_ack        <= NCH'(1) << pick;
                        MEM_exec     <= 1'b1;
                        O_busy       <= 1'b1;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    // MEM_data_ready is deliberately not looked at here.
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end

                WAIT: begin
                    if (MEM_data_ready) begin
                        if (!MEM_write) begin
                            O_data <= MEM_data_in;
                        end
                        O_data_ready <= NCH'(1) << grant;
                        state        <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // The abort fires on the TIMEOUT-th WAIT cycle.
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        O_data       <= '0;
                        error_q      <= 1'b1;
                        O_data_ready <= NCH'(1) << grant;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    last_grant <= grant;
                    O_busy     <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    O_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
